// File: rtl/lb_scanout_if.sv
// Line-buffer RAM port bundle: address/write strobe/write data out of the
// scan-out block, synchronous read data back into it.
interface lb_scanout_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 12
);
   logic [ADDR_W-1:0] LB_ADDR;
   logic              LB_WE;
   logic [DATA_W-1:0] LB_WDATA;
   logic [DATA_W-1:0] LB_RDATA;

   modport master (output LB_ADDR, output LB_WE, output LB_WDATA, input LB_RDATA);
   modport slave  (input LB_ADDR, input LB_WE, input LB_WDATA, output LB_RDATA);
endinterface

// File: rtl/lb_scanout.sv
// Line-buffer scan-out: one pixel per PIX_EN from a sync-read RAM. With
// LB_SCANOUT_CLEAR_EN defined, each read pixel is overwritten with BACKDROP.
module lb_scanout #(
   parameter int                ADDR_W      = 8,
   parameter int                DATA_W      = 12,
   parameter int                LINE_PIXELS = 192,
   parameter logic [DATA_W-1:0] BACKDROP    = {DATA_W{1'b1}}
) (
   input  logic               CLK,
   input  logic               nRESET,
   input  logic               LINE_START,
   input  logic [ADDR_W-1:0]  START_ADDR,
   input  logic               PIX_EN,
   lb_scanout_if.master       lb,
   output logic [DATA_W-1:0]  PIX_OUT,
   output logic               PIX_VALID,
   output logic               BUSY,
   output logic               LINE_DONE,
   output logic               OVERRUN
);

   // state | meaning
   // IDLE  | no line in progress
   // WAIT  | address counter on LB_ADDR, waiting for PIX_EN
   // RD    | RAM read in flight, address held
   // CAP   | PIX_OUT/PIX_VALID presented
   // CLR   | BACKDROP written to the pixel just read (clear build only)
`ifdef LB_SCANOUT_CLEAR_EN
   typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_RD, ST_CAP, ST_CLR} state_t;
`else
   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RD, ST_CAP} state_t;
`endif

   localparam int              CNT_W    = ADDR_W + 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LINE_PIXELS - 1);

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] addr_cnt;
   logic [CNT_W-1:0]  pix_cnt;
   logic              adv, done, cap_load, set_ovr;

   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) state <= ST_IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      adv       = 1'b0;
      done      = 1'b0;
      cap_load  = 1'b0;
      set_ovr   = 1'b0;
      case (state)
         ST_IDLE: ;
         ST_WAIT: if (PIX_EN) state_nxt = ST_RD;
         ST_RD: begin
            state_nxt = ST_CAP;
            cap_load  = 1'b1;
         end
`ifdef LB_SCANOUT_CLEAR_EN
         ST_CAP: state_nxt = ST_CLR;
         ST_CLR: adv = 1'b1;
`else
         ST_CAP: adv = 1'b1;
`endif
         default: state_nxt = ST_IDLE;
      endcase
      if (adv) begin
         done      = (pix_cnt == LAST_CNT);
         state_nxt = done ? ST_IDLE : ST_WAIT;
      end
      if (PIX_EN && (state != ST_WAIT)) set_ovr = 1'b1;
      // A new line wins over everything, including a pixel still in flight.
      if (LINE_START) begin
         state_nxt = ST_WAIT;
         adv       = 1'b0;
         done      = 1'b0;
         cap_load  = 1'b0;
         set_ovr   = 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) begin
         addr_cnt  <= '0;
         pix_cnt   <= '0;
         PIX_OUT   <= '0;
         PIX_VALID <= 1'b0;
         LINE_DONE <= 1'b0;
         OVERRUN   <= 1'b0;
      end else begin
         PIX_VALID <= cap_load;
         LINE_DONE <= done;
         if (cap_load) PIX_OUT <= lb.LB_RDATA;
         if (LINE_START) begin
            addr_cnt <= START_ADDR;
            pix_cnt  <= '0;
            OVERRUN  <= 1'b0;
         end else begin
            if (adv) begin
               addr_cnt <= addr_cnt + 1'b1;
               pix_cnt  <= pix_cnt + 1'b1;
            end
            if (set_ovr) OVERRUN <= 1'b1;
         end
      end
   end

   // The counter only moves after the pixel's accesses, so it doubles as the
   // read address (presented in WAIT for the sync RAM) and the clear address.
   assign lb.LB_ADDR  = addr_cnt;
   assign lb.LB_WDATA = BACKDROP;
`ifdef LB_SCANOUT_CLEAR_EN
   assign lb.LB_WE    = (state == ST_CLR);
`else
   assign lb.LB_WE    = 1'b0;
`endif
   assign BUSY        = (state != ST_IDLE);

endmodule

// File: tb/tb_lb_scanout.sv
// Scoreboard bench for lb_scanout: stimulus pushes expected pixels, writes and
// line-done events; one monitor process checks everything on the falling edge.
module tb_lb_scanout;
   localparam int ADDR_W = 8;
   localparam int DATA_W = 12;
   localparam int NPIX   = 4;
   localparam logic [DATA_W-1:0] BD = {DATA_W{1'b1}};
`ifdef LB_SCANOUT_CLEAR_EN
   localparam bit CLR_EN  = 1'b1;
   localparam int SPACING = 4;
`else
   localparam bit CLR_EN  = 1'b0;
   localparam int SPACING = 3;
`endif

   logic CLK = 1'b0, nRESET = 1'b0, LINE_START = 1'b0, PIX_EN = 1'b0;
   logic [ADDR_W-1:0] START_ADDR = '0;
   logic [DATA_W-1:0] PIX_OUT;
   logic PIX_VALID, BUSY, LINE_DONE, OVERRUN;

   lb_scanout_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) lb ();

   lb_scanout #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_PIXELS(NPIX), .BACKDROP(BD)) dut (
      .CLK(CLK), .nRESET(nRESET), .LINE_START(LINE_START), .START_ADDR(START_ADDR),
      .PIX_EN(PIX_EN), .lb(lb), .PIX_OUT(PIX_OUT), .PIX_VALID(PIX_VALID),
      .BUSY(BUSY), .LINE_DONE(LINE_DONE), .OVERRUN(OVERRUN));

   always #5 CLK = ~CLK;

   // RAM model with a preload port used only while the DUT is held in reset
   logic [DATA_W-1:0] ram [256];
   logic              ld_en = 1'b0;
   logic [ADDR_W-1:0] ld_addr = '0;
   logic [DATA_W-1:0] ld_data = '0;
   always @(posedge CLK) begin
      if (ld_en)          ram[ld_addr] <= ld_data;
      else if (lb.LB_WE)  ram[lb.LB_ADDR] <= lb.LB_WDATA;
      lb.LB_RDATA <= ram[lb.LB_ADDR];
   end

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   typedef struct { logic [DATA_W-1:0] d; int due; } pix_t;
   typedef struct { int a; int due; } wr_t;
   pix_t pq[$];
   wr_t  wq[$];
   int   dq[$];

   logic [DATA_W-1:0] ref_mem [256];
   logic exp_busy = 1'b0, exp_ovr = 1'b0;
   int   cur_addr = 0, cnt = 0;
   int   chk_req = 0, chk_ack = 0;
   int   total = 0, bad = 0;

   pix_t mp;
   wr_t  mw;
   int   md;
   logic [DATA_W-1:0] last_pix = '0;

   always @(negedge CLK) begin
      total++;
      if (BUSY !== exp_busy) begin bad++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, BUSY, exp_busy); end
      total++;
      if (OVERRUN !== exp_ovr) begin bad++; $display("FAIL overrun cyc=%0d got=%b exp=%b", cyc, OVERRUN, exp_ovr); end
      if (!nRESET) begin
         pq.delete(); dq.delete();
         last_pix = '0;
         total++;
         if (PIX_OUT !== '0 || PIX_VALID !== 1'b0 || LINE_DONE !== 1'b0 || lb.LB_WE !== 1'b0 ||
             lb.LB_ADDR !== '0 || lb.LB_WDATA !== BD) begin
            bad++;
            $display("FAIL reset_vals cyc=%0d got pix=%h v=%b done=%b we=%b addr=%h wd=%h exp 000/0/0/0/00/%h",
                     cyc, PIX_OUT, PIX_VALID, LINE_DONE, lb.LB_WE, lb.LB_ADDR, lb.LB_WDATA, BD);
         end
      end else begin
         if (PIX_VALID) begin
            total++;
            if (pq.size() == 0) begin
               bad++; $display("FAIL pix_extra cyc=%0d got=%h exp=none", cyc, PIX_OUT);
            end else begin
               mp = pq.pop_front();
               if (PIX_OUT !== mp.d || cyc != mp.due) begin
                  bad++;
                  $display("FAIL pix_data cyc=%0d got=%h exp=%h due=%0d", cyc, PIX_OUT, mp.d, mp.due);
               end
               last_pix = mp.d;
            end
         end else begin
            total++;
            if (PIX_OUT !== last_pix) begin bad++; $display("FAIL pix_hold cyc=%0d got=%h exp=%h", cyc, PIX_OUT, last_pix); end
            if (pq.size() > 0 && cyc > pq[0].due) begin
               bad++; $display("FAIL pix_missing cyc=%0d got=none exp=%h", cyc, pq[0].d);
               void'(pq.pop_front());
            end
         end
         if (LINE_DONE) begin
            total++;
            if (dq.size() == 0) begin
               bad++; $display("FAIL done_extra cyc=%0d got=1 exp=0", cyc);
            end else begin
               md = dq.pop_front();
               if (cyc != md) begin bad++; $display("FAIL done_time got=%0d exp=%0d", cyc, md); end
            end
         end else if (dq.size() > 0 && cyc > dq[0]) begin
            total++; bad++;
            $display("FAIL done_missing cyc=%0d got=0 exp_at=%0d", cyc, dq[0]);
            void'(dq.pop_front());
         end
         if (lb.LB_WE) begin
            total++;
            if (wq.size() == 0) begin
               bad++; $display("FAIL wr_extra cyc=%0d got_addr=%h exp=none", cyc, lb.LB_ADDR);
            end else begin
               mw = wq.pop_front();
               if (int'(lb.LB_ADDR) != mw.a || cyc != mw.due || lb.LB_WDATA !== BD) begin
                  bad++;
                  $display("FAIL wr cyc=%0d got addr=%h data=%h exp addr=%h data=%h due=%0d",
                           cyc, lb.LB_ADDR, lb.LB_WDATA, mw.a[7:0], BD, mw.due);
               end
            end
         end
      end
      if (chk_ack != chk_req) begin
         for (int i = 0; i < 256; i++) begin
            total++;
            if (ram[i] !== ref_mem[i]) begin bad++; $display("FAIL ram[%0d] got=%h exp=%h", i, ram[i], ref_mem[i]); end
         end
         total++;
         if (pq.size() != 0 || wq.size() != 0 || dq.size() != 0) begin
            bad++; $display("FAIL pending got pix=%0d wr=%0d done=%0d exp 0/0/0", pq.size(), wq.size(), dq.size());
         end
         chk_ack = chk_req;
      end
   end

   task automatic tick();
      @(posedge CLK); #1;
   endtask

   task automatic line_start(input int a);
      LINE_START = 1'b1; START_ADDR = ADDR_W'(a);
      tick();
      LINE_START = 1'b0;
      exp_ovr = 1'b0; exp_busy = 1'b1; cur_addr = a % 256; cnt = 0;
   endtask

   // Expectations for one pixel; inj = 1..SPACING-1 adds a premature PIX_EN.
   task automatic pix(input int extra, input int inj);
      pix_t p;
      wr_t  w;
      p.d = ref_mem[cur_addr]; p.due = cyc + 2; pq.push_back(p);
      if (CLR_EN) begin
         w.a = cur_addr; w.due = cyc + 3; wq.push_back(w);
         ref_mem[cur_addr] = BD;
      end
      if (cnt == NPIX - 1) dq.push_back(cyc + SPACING);
      PIX_EN = 1'b1; tick(); PIX_EN = 1'b0;
      for (int i = 1; i < SPACING; i++) begin
         if (inj == i) PIX_EN = 1'b1;
         tick();
         PIX_EN = 1'b0;
         if (inj == i) exp_ovr = 1'b1;
      end
      cur_addr = (cur_addr + 1) % 256;
      cnt++;
      if (cnt == NPIX) exp_busy = 1'b0;
      repeat (extra) tick();
   endtask

   task automatic idle_pix();
      PIX_EN = 1'b1; tick(); PIX_EN = 1'b0;
      exp_ovr = 1'b1;
   endtask

   task automatic ram_check();
      chk_req++;
      for (int t = 0; t < 20 && chk_ack != chk_req; t++) tick();
      if (chk_ack != chk_req) begin
         $display("FAIL ram_check timeout got_ack=%0d exp=%0d", chk_ack, chk_req);
         $fatal(1);
      end
   endtask

   initial begin
      pix_t p;
      int   inj;
      for (int i = 0; i < 256; i++) begin
         ld_en = 1'b1; ld_addr = ADDR_W'(i);
         ld_data = (i < NPIX) ? DATA_W'(i + 1) : DATA_W'($urandom_range(0, 4094));
         ref_mem[i] = ld_data;
         tick();
      end
      ld_en = 1'b0;
      repeat (2) tick();
      nRESET = 1'b1;
      repeat (3) tick();

      // basic line at 00, PIX_EN every 4 clocks
      line_start(0);
      for (int i = 0; i < NPIX; i++) pix(4 - SPACING, 0);
      repeat (3) tick();
      ram_check();

      // address wrap FE, FF, 00, 01
      line_start(254);
      for (int i = 0; i < NPIX; i++) pix(0, 0);
      repeat (2) tick();

      // premature PIX_EN one clock after the first
      line_start(40);
      pix(0, 1);
      for (int i = 1; i < NPIX; i++) pix(1, 0);
      repeat (2) tick();
      line_start(50);
      for (int i = 0; i < NPIX; i++) pix(0, 0);
      repeat (2) tick();

      // LINE_START during CAP of pixel 2
      line_start(60);
      pix(0, 0);
      p.d = ref_mem[cur_addr]; p.due = cyc + 2; pq.push_back(p);
      PIX_EN = 1'b1; tick(); PIX_EN = 1'b0;
      tick();
      line_start(16);
      for (int i = 0; i < NPIX; i++) pix(0, 0);
      repeat (2) tick();
      ram_check();

      // reset during RD
      line_start(32);
      p.d = ref_mem[cur_addr]; p.due = cyc + 2; pq.push_back(p);
      PIX_EN = 1'b1; tick(); PIX_EN = 1'b0;
      nRESET = 1'b0; exp_busy = 1'b0; exp_ovr = 1'b0;
      repeat (2) tick();
      nRESET = 1'b1;
      repeat (3) tick();
      idle_pix();
      repeat (3) tick();
      ram_check();

      // randomized lines
      for (int n = 0; n < 20; n++) begin
         line_start(int'($urandom_range(0, 255)));
         for (int i = 0; i < NPIX; i++) begin
            inj = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, SPACING - 1)) : 0;
            pix(int'($urandom_range(0, 2)), inj);
         end
         repeat ($urandom_range(1, 3)) tick();
         if ($urandom_range(0, 4) == 0) idle_pix();
      end
      repeat (4) tick();
      ram_check();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
